// File: rtl/nn_pkg.sv
// Shared constants and types for the network's output stage.
package nn_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned GUESS_W     = 32;

  typedef logic signed [DATA_W-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/argmax_classifier_if.sv
// Score input stream and guess result stream of the argmax classifier.
interface argmax_classifier_if;
  import nn_pkg::*;

  logic                 score_valid;
  logic                 score_ready;
  score_t               score_data;
  logic                 score_last;
  logic                 guess_valid;
  logic                 guess_ready;
  logic [GUESS_W-1:0]   guess;
  score_t               max_score;
  logic                 error;

  // Classifier side.
  modport slave (
    input  score_valid, score_data, score_last, guess_ready,
    output score_ready, guess_valid, guess, max_score, error
  );

  // Upstream producer / downstream consumer side.
  modport master (
    output score_valid, score_data, score_last, guess_ready,
    input  score_ready, guess_valid, guess, max_score, error
  );

endinterface

// File: rtl/score_compare.sv
// Combinational signed greater-than; isolated so a float comparator can replace it.
module score_compare
  import nn_pkg::*;
(
  input  score_t i_score,
  input  score_t i_best,
  output logic   o_take_c,
  output score_t o_best_c
);

  // Strict compare keeps the earlier (lower) index on ties.
  assign o_take_c = (i_score > i_best);
  assign o_best_c = o_take_c ? i_score : i_best;

endmodule

// File: rtl/argmax_classifier.sv
// Running-max argmax over NUM_CLASSES signed scores; emits winning index per image.
module argmax_classifier
  import nn_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  argmax_classifier_if.slave  bus
);

  argmax_state_t      r_state;
  logic [IDX_W-1:0]   r_count;
  score_t             r_best;
  logic [IDX_W-1:0]   r_best_idx;
  logic               r_score_ready;
  logic               r_guess_valid;
  logic [GUESS_W-1:0] r_guess;
  score_t             r_max_score;
  logic               r_error;

  logic               w_hs;
  logic               w_last_idx;
  logic               w_final;
  logic               w_err;
  logic               w_take;
  score_t             w_cmp_best;
  score_t             w_next_best;
  logic [IDX_W-1:0]   w_next_idx;

  score_compare u_cmp (
    .i_score  (bus.score_data),
    .i_best   (r_best),
    .o_take_c (w_take),
    .o_best_c (w_cmp_best)
  );

  assign w_hs       = bus.score_valid && r_score_ready;
  // r_count equals the arrival index of the score currently on the bus.
  assign w_last_idx = (r_count == IDX_W'(NUM_CLASSES - 1));
  assign w_final    = w_hs && (bus.score_last || w_last_idx);
  assign w_err      = (bus.score_last != w_last_idx);

  // First score of an image seeds the running max unconditionally.
  assign w_next_best = (r_state == IDLE) ? bus.score_data : w_cmp_best;
  assign w_next_idx  = (r_state == IDLE) ? '0 :
                       (w_take ? r_count : r_best_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_best        <= '0;
      r_best_idx    <= '0;
      r_score_ready <= 1'b0;
      r_guess_valid <= 1'b0;
      r_guess       <= '0;
      r_max_score   <= '0;
      r_error       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          r_score_ready <= 1'b1;
          if (w_hs) begin
            r_best     <= w_next_best;
            r_best_idx <= w_next_idx;
            r_count    <= r_count + IDX_W'(1);
            if (w_final) begin
              r_state       <= DONE;
              r_score_ready <= 1'b0;
              r_guess_valid <= 1'b1;
              r_guess       <= GUESS_W'(w_next_idx);
              r_max_score   <= w_next_best;
              r_error       <= w_err;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (bus.guess_ready) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_score_ready <= 1'b1;
            r_guess_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_count       <= '0;
          r_score_ready <= 1'b0;
          r_guess_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.score_ready = r_score_ready;
  assign bus.guess_valid = r_guess_valid;
  assign bus.guess       = r_guess;
  assign bus.max_score   = r_max_score;
  assign bus.error       = r_error;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed self-checking bench for argmax_classifier.
module tb_argmax_classifier;
  import nn_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  score_t img [10];

  argmax_classifier_if bus ();

  argmax_classifier u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one score; returns #1 after the edge where it transferred.
  task automatic send(input score_t d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    bus.score_valid = 1'b1;
    bus.score_data  = d;
    bus.score_last  = last;
    while (!bus.score_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    bus.score_valid = 1'b0;
    bus.score_last  = 1'b0;
  endtask

  task automatic send_img(input int n, input logic last, input int gap);
    for (int i = 0; i < n; i++) begin
      send(img[i], last && (i == n - 1));
      if (i != n - 1) repeat (gap) @(posedge clk);
    end
  endtask

  task automatic expect_result(input string tag, input logic [31:0] g, input score_t m, input logic e);
    chk({tag, "_gv"},    32'(bus.guess_valid), 32'd1);
    chk({tag, "_guess"}, bus.guess, g);
    chk({tag, "_max"},   bus.max_score, m);
    chk({tag, "_err"},   32'(bus.error), 32'(e));
    chk({tag, "_sr"},    32'(bus.score_ready), 32'd0);
  endtask

  task automatic consume(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_gv_drop"}, 32'(bus.guess_valid), 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset           = 1'b1;
    bus.score_valid = 1'b0;
    bus.score_data  = '0;
    bus.score_last  = 1'b0;
    bus.guess_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_gv",    32'(bus.guess_valid), 32'd0);
    chk("rst_sr",    32'(bus.score_ready), 32'd0);
    chk("rst_guess", bus.guess, 32'd0);
    chk("rst_max",   bus.max_score, 32'd0);
    chk("rst_err",   32'(bus.error), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_sr", 32'(bus.score_ready), 32'd1);

    // 1: ascending, max at last index; guess_valid right after 10th score
    img = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd6, 32'sd7, 32'sd8, 32'sd9, 32'sd100};
    send_img(9, 1'b0, 0);
    chk("t1_gv_before", 32'(bus.guess_valid), 32'd0);
    send(img[9], 1'b1);
    expect_result("t1", 32'd9, 32'sd100, 1'b0);
    consume("t1");

    // 2: all equal with gaps in the stream -> lowest index wins
    for (int i = 0; i < 10; i++) img[i] = 32'sd5;
    send_img(10, 1'b1, 2);
    expect_result("t2", 32'd0, 32'sd5, 1'b0);
    consume("t2");

    // 3: negatives, signed compare
    img = '{-32'sd1, -32'sd7, 32'sh8000_0000, -32'sd2, -32'sd4,
            -32'sd5, -32'sd6, -32'sd8, -32'sd9, -32'sd3};
    send_img(10, 1'b1, 0);
    expect_result("t3", 32'd0, 32'shFFFF_FFFF, 1'b0);
    consume("t3");

    // 4: backpressure in DONE while upstream keeps score_valid high
    bus.guess_ready = 1'b0;
    img = '{32'sd4, 32'sd8, 32'sd15, 32'sd16, 32'sd23, 32'sd42, 32'sd7, 32'sd42, 32'sd1, 32'sd0};
    send_img(10, 1'b1, 0);
    expect_result("t4a", 32'd5, 32'sd42, 1'b0);
    @(negedge clk);
    bus.score_valid = 1'b1;
    bus.score_data  = 32'sd77;
    bus.score_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_hold_sr",    32'(bus.score_ready), 32'd0);
      chk("t4_hold_gv",    32'(bus.guess_valid), 32'd1);
      chk("t4_hold_guess", bus.guess, 32'd5);
    end
    bus.guess_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_release_gv", 32'(bus.guess_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.score_valid = 1'b0;
    for (int i = 1; i < 10; i++) send(32'(i), i == 9);
    expect_result("t4b", 32'd0, 32'sd77, 1'b0);
    consume("t4b");

    // Tenth score without last -> DONE anyway, error
    img = '{32'sd2, 32'sd2, 32'sd2, 32'sd2, 32'sd2, 32'sd2, 32'sd2, 32'sd2, 32'sd2, 32'sd3};
    send_img(10, 1'b0, 0);
    expect_result("nolast", 32'd9, 32'sd3, 1'b1);
    consume("nolast");

    // 5: early last on 6th score
    img = '{32'sd3, 32'sd1, 32'sd4, 32'sd1, 32'sd5, 32'sd9, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    send_img(6, 1'b1, 0);
    expect_result("t5", 32'd5, 32'sd9, 1'b1);
    consume("t5");
    img = '{32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd12, 32'sd0, 32'sd0};
    send_img(10, 1'b1, 0);
    expect_result("t5_clean", 32'd7, 32'sd12, 1'b0);
    consume("t5_clean");

    // 6: reset mid-image discards stale best and count
    img = '{32'sd10, 32'sd20, 32'sd30, 32'sd99, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    send_img(4, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_gv",    32'(bus.guess_valid), 32'd0);
    chk("t6_rst_sr",    32'(bus.score_ready), 32'd0);
    chk("t6_rst_guess", bus.guess, 32'd0);
    chk("t6_rst_max",   bus.max_score, 32'd0);
    reset = 1'b0;
    img = '{32'sd0, 32'sd0, 32'sd0, 32'sd50, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    send_img(9, 1'b0, 0);
    chk("t6_gv_before", 32'(bus.guess_valid), 32'd0);
    send(img[9], 1'b1);
    expect_result("t6", 32'd3, 32'sd50, 1'b0);
    consume("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
